// File: rtl/ahb_pkg.sv
// Shared AHB arbitration types and constants: transfer encodings, master IDs, burst hold limit.
package ahb_pkg;
  localparam int AHB_TRANS_BITS  = 2;
  localparam int AHB_MASTER_BITS = 2;
  localparam int AHB_BEAT_BITS   = 5;

  typedef enum logic [AHB_TRANS_BITS-1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [AHB_MASTER_BITS-1:0] MST_DEFAULT = 2'd0;
  localparam logic [AHB_MASTER_BITS-1:0] MST_M1      = 2'd1;
  localparam logic [AHB_MASTER_BITS-1:0] MST_M2      = 2'd2;

  localparam logic [AHB_BEAT_BITS-1:0] AHB_ARB_MAX_HOLD = 5'd16;

  // Grant vector bit0 = M1, bit1 = M2; zero maps to the default master.
  function automatic logic [AHB_MASTER_BITS-1:0] grant_to_id(input logic [1:0] gnt);
    if (gnt[0])      return MST_M1;
    else if (gnt[1]) return MST_M2;
    else             return MST_DEFAULT;
  endfunction
endpackage

// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the two AHB masters (master modport) and the arbiter (slave modport).
interface ahb_arbiter_if;
  import ahb_pkg::*;

  logic                       HBUSREQ_M1;
  logic                       HBUSREQ_M2;
  logic                       HLOCK_M1;
  logic                       HLOCK_M2;
  logic [AHB_TRANS_BITS-1:0]  HTRANS;
  logic                       HREADY;
  logic                       HGRANT_M1;
  logic                       HGRANT_M2;
  logic [AHB_MASTER_BITS-1:0] HMASTER;
  logic                       HMASTLOCK;

  modport master (
    output HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HTRANS, HREADY,
    input  HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HTRANS, HREADY,
    output HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational tie-break: request vector (+ last winner) -> one-hot-or-zero grant.
// AHB_ARB_FIXED_PRIO_EN selects fixed M1-over-M2 priority instead of round-robin.
module ahb_arb_pick
  import ahb_pkg::*;
(
  input  logic [1:0]                 req,
`ifndef AHB_ARB_FIXED_PRIO_EN
  input  logic [AHB_MASTER_BITS-1:0] rr_last,
`endif
  output logic [1:0]                 gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
`ifdef AHB_ARB_FIXED_PRIO_EN
        gnt = 2'b01;
`else
        gnt = (rr_last == MST_M1) ? 2'b10 : 2'b01;
`endif
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: grant registered 1 cycle after decision, HMASTER/HMASTLOCK follow on HREADY.
// Bursts and locked sequences hold the grant; AHB_ARB_FIXED_PRIO_EN replaces round-robin ties.
module ahb_arbiter
  import ahb_pkg::*;
(
  input logic          HCLK,
  input logic          HRESET,
  ahb_arbiter_if.slave bus
);

  logic [1:0]                 req;
  logic [1:0]                 gnt_pick;
  logic [1:0]                 gnt_q;
  logic [AHB_MASTER_BITS-1:0] hmaster_q;
  logic                       hmastlock_q;
  logic [AHB_BEAT_BITS-1:0]   beat_cnt;
  logic                       owner_lock;
  logic                       granted_lock;
  logic                       in_burst;
  logic                       hold;
  logic                       arb_en;

  assign req = {bus.HBUSREQ_M2, bus.HBUSREQ_M1};

`ifdef AHB_ARB_FIXED_PRIO_EN
  ahb_arb_pick u_pick (
    .req (req),
    .gnt (gnt_pick)
  );
`else
  logic [AHB_MASTER_BITS-1:0] rr_last;

  ahb_arb_pick u_pick (
    .req     (req),
    .rr_last (rr_last),
    .gnt     (gnt_pick)
  );

  // Reset to M2 so M1 takes the first tie.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                  rr_last <= MST_M2;
    else if (arb_en && |gnt_pick) rr_last <= grant_to_id(gnt_pick);
  end
`endif

  always_comb begin
    owner_lock = 1'b0;
    if (hmaster_q == MST_M1)      owner_lock = bus.HLOCK_M1;
    else if (hmaster_q == MST_M2) owner_lock = bus.HLOCK_M2;
  end

  always_comb begin
    granted_lock = 1'b0;
    if (gnt_q[0])      granted_lock = bus.HLOCK_M1;
    else if (gnt_q[1]) granted_lock = bus.HLOCK_M2;
  end

  // Unlocked bursts hold only until the beat limit, forcing early termination.
  assign in_burst = (bus.HTRANS == TRANS_BUSY) || (bus.HTRANS == TRANS_SEQ);
  assign hold     = (hmastlock_q && owner_lock) || (in_burst && (beat_cnt < AHB_ARB_MAX_HOLD));
  assign arb_en   = bus.HREADY && !hold;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      gnt_q <= 2'b00;
    else if (arb_en) gnt_q <= gnt_pick;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hmaster_q   <= MST_DEFAULT;
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      hmaster_q   <= grant_to_id(gnt_q);
      hmastlock_q <= granted_lock;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      beat_cnt <= '0;
    end else if (bus.HREADY) begin
      if ((bus.HTRANS == TRANS_NONSEQ) || (bus.HTRANS == TRANS_IDLE))
        beat_cnt <= '0;
      else if ((bus.HTRANS == TRANS_SEQ) && (beat_cnt != AHB_ARB_MAX_HOLD))
        beat_cnt <= beat_cnt + 5'd1;
    end
  end

  assign bus.HGRANT_M1 = gnt_q[0];
  assign bus.HGRANT_M2 = gnt_q[1];
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, single request, round-robin, burst hold, hold limit, lock, wait states.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic HCLK;
  logic HRESET;
  int   n_cmp;
  int   n_err;

  ahb_arbiter_if bus ();

  ahb_arbiter dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    chk("grant_exclusive", {7'd0, bus.HGRANT_M1 & bus.HGRANT_M2}, 8'd0);
  endtask

  task automatic chk_gnt(input string tag, input logic [1:0] exp);
    chk(tag, {6'd0, bus.HGRANT_M2, bus.HGRANT_M1}, {6'd0, exp});
  endtask

  task automatic drive(input logic r1, input logic r2, input logic [1:0] tr);
    bus.HBUSREQ_M1 = r1;
    bus.HBUSREQ_M2 = r2;
    bus.HTRANS     = tr;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    HRESET         = 1'b1;
    bus.HLOCK_M1   = 1'b0;
    bus.HLOCK_M2   = 1'b0;
    bus.HREADY     = 1'b1;
    drive(1'b0, 1'b0, TRANS_IDLE);

    // Reset state
    tick();
    tick();
    chk_gnt("reset_grant", 2'b00);
    chk("reset_hmaster", {6'd0, bus.HMASTER}, 8'd0);
    chk("reset_hmastlock", {7'd0, bus.HMASTLOCK}, 8'd0);
    HRESET = 1'b0;

    // Single requester: grant after 1 cycle, HMASTER after 2
    drive(1'b1, 1'b0, TRANS_IDLE);
    tick();
    chk_gnt("single_grant", 2'b01);
    chk("single_hmaster_lag", {6'd0, bus.HMASTER}, 8'd0);
    tick();
    chk("single_hmaster", {6'd0, bus.HMASTER}, 8'd1);

    // Round-robin: prime M2 as last winner, then tie with NONSEQ singles
    drive(1'b0, 1'b1, TRANS_NONSEQ);
    tick();
    chk_gnt("rr_prime", 2'b10);
    drive(1'b1, 1'b1, TRANS_NONSEQ);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_gnt("rr_grant", (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_hmaster", {6'd0, bus.HMASTER}, (i % 2 == 0) ? 8'd2 : 8'd1);
    end

    // Burst hold: M1 NONSEQ + 3 SEQ, M2 requests from the first SEQ
    drive(1'b1, 1'b0, TRANS_IDLE);
    tick();
    tick();
    chk("burst_owner", {6'd0, bus.HMASTER}, 8'd1);
    drive(1'b1, 1'b0, TRANS_NONSEQ);
    tick();
    chk_gnt("burst_nonseq", 2'b01);
    drive(1'b1, 1'b1, TRANS_SEQ);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gnt("burst_seq_hold", 2'b01);
    end
    drive(1'b0, 1'b1, TRANS_IDLE);
    tick();
    chk_gnt("burst_release", 2'b10);

    // Hold limit: NONSEQ + 20 SEQ, grant moves to M2 once 16 SEQ beats are counted
    drive(1'b1, 1'b0, TRANS_IDLE);
    tick();
    tick();
    chk("limit_owner", {6'd0, bus.HMASTER}, 8'd1);
    drive(1'b1, 1'b0, TRANS_NONSEQ);
    tick();
    for (int k = 1; k <= 20; k++) begin
      drive((k <= 17) ? 1'b1 : 1'b0, 1'b1, TRANS_SEQ);
      tick();
      chk_gnt($sformatf("limit_seq%0d", k), (k >= 17) ? 2'b10 : 2'b01);
    end

    // Lock: M2 locked keeps grant against M1 until HLOCK_M2 drops
    bus.HLOCK_M2 = 1'b1;
    drive(1'b0, 1'b1, TRANS_IDLE);
    tick();
    chk_gnt("lock_grant", 2'b10);
    chk("lock_mastlock", {7'd0, bus.HMASTLOCK}, 8'd1);
    drive(1'b1, 1'b1, TRANS_NONSEQ);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gnt("lock_hold", 2'b10);
      chk("lock_mastlock_hold", {7'd0, bus.HMASTLOCK}, 8'd1);
    end
    bus.HLOCK_M2 = 1'b0;
    tick();
    chk_gnt("lock_release", 2'b01);
    chk("lock_mastlock_drop", {7'd0, bus.HMASTLOCK}, 8'd0);

    // Wait states across a grant change: HMASTER frozen while HREADY=0
    drive(1'b1, 1'b0, TRANS_IDLE);
    tick();
    chk("wait_owner", {6'd0, bus.HMASTER}, 8'd1);
    drive(1'b0, 1'b1, TRANS_IDLE);
    tick();
    chk_gnt("wait_grant_change", 2'b10);
    bus.HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_hmaster_hold", {6'd0, bus.HMASTER}, 8'd1);
      chk_gnt("wait_grant_hold", 2'b10);
    end
    bus.HREADY = 1'b1;
    tick();
    chk("wait_hmaster_update", {6'd0, bus.HMASTER}, 8'd2);

    // Reset mid-burst drops everything asynchronously; M1 wins the first tie after
    drive(1'b0, 1'b1, TRANS_SEQ);
    tick();
    chk_gnt("rst_burst_grant", 2'b10);
    #2;
    HRESET = 1'b1;
    #1;
    chk_gnt("rst_async_grant", 2'b00);
    chk("rst_async_hmaster", {6'd0, bus.HMASTER}, 8'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    drive(1'b1, 1'b1, TRANS_IDLE);
    tick();
    chk_gnt("rst_first_tie", 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
